// File: rtl/sd_card_responder.sv
// sd_card_responder
//   Behavioural stand-in for an SD card as seen by a RAID controller. It
//   accepts one block command at a time and moves the block's 32-bit words
//   through a simple synchronous backing-memory port.
//
//   Writes are forwarded to memory combinationally in the cycle of the
//   strobe. Reads are issued in the strobe cycle, come back from memory one
//   cycle later, and are registered onto sd_out one cycle after that.
//
// Ports
//   clk            single clock, rising edge
//   n_rst          asynchronous reset, active HIGH despite the name
//   sd_start       command strobe; sd_mode / sd_block_no are sampled with it
//   sd_mode        1 = write block to card, 0 = read block from card
//   sd_block_no    target block number
//   sd_load_enable per-word transfer strobe
//   sd_in          write data word
//   sd_out         read data word (holds between completions)
//   sd_out_valid   sd_out carries a newly completed read word this cycle
//   sd_ready       idle, a start will be accepted
//   sd_error       00 ok, 01 block out of range, 10 start while busy
//   mem_addr       {block, word offset}
//   mem_wen        memory write strobe
//   mem_ren        memory read strobe
//   mem_wdata      memory write data
//   mem_rdata      memory read data, valid one cycle after mem_ren
module sd_card_responder #(
  parameter int BLOCK_WORDS = 128,
  parameter int NUM_BLOCKS  = 512
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        sd_start,
  input  logic        sd_mode,
  input  logic [31:0] sd_block_no,
  input  logic        sd_load_enable,
  input  logic [31:0] sd_in,
  output logic [31:0] sd_out,
  output logic        sd_out_valid,
  output logic        sd_ready,
  output logic [1:0]  sd_error,
  output logic [15:0] mem_addr,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // The word offset fills the low address bits, the block number the rest.
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int BLK_W = 16 - OFF_W;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(BLOCK_WORDS - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WRITE_RX = 3'd1;
  localparam logic [2:0] READ_TX  = 3'd2;
  localparam logic [2:0] DRAIN    = 3'd3;
  localparam logic [2:0] REJECT   = 3'd4;

  logic [2:0]       state_reg, state_next;
  logic [OFF_W-1:0] offset_reg, offset_next;
  logic [BLK_W-1:0] block_reg, block_next;
  logic [1:0]       error_reg, error_next;
  logic             rd_pend_reg;
  logic [31:0]      sd_out_reg;
  logic             sd_out_valid_reg;

  logic in_range;
  logic wr_strobe;
  logic rd_strobe;

  // Whole 32-bit compare, so huge block numbers are rejected rather than
  // aliased onto a low block by truncation.
  assign in_range  = sd_block_no < 32'(NUM_BLOCKS);

  // Memory strobes are qualified by state, so sd_load_enable has no effect
  // in IDLE, DRAIN and REJECT. The two states are exclusive, which also
  // keeps mem_wen and mem_ren from ever being high together.
  assign wr_strobe = (state_reg == WRITE_RX) && sd_load_enable;
  assign rd_strobe = (state_reg == READ_TX)  && sd_load_enable;

  always_comb begin
    state_next  = state_reg;
    offset_next = offset_reg;
    block_next  = block_reg;
    error_next  = error_reg;

    case (state_reg)
      IDLE: begin
        if (sd_start) begin
          if (in_range) begin
            block_next  = sd_block_no[BLK_W-1:0];
            offset_next = '0;
            error_next  = 2'b00;
            state_next  = sd_mode ? WRITE_RX : READ_TX;
          end else begin
            error_next  = 2'b01;
            state_next  = REJECT;
          end
        end
      end
      WRITE_RX: begin
        if (sd_load_enable) begin
          offset_next = offset_reg + 1'b1;  // wraps to 0 after the last word
          if (offset_reg == LAST_OFF) state_next = IDLE;
        end
      end
      READ_TX: begin
        if (sd_load_enable) begin
          offset_next = offset_reg + 1'b1;
          if (offset_reg == LAST_OFF) state_next = DRAIN;
        end
      end
      // The last read's data is in mem_rdata during this cycle and is
      // captured onto sd_out on the same edge that returns to IDLE.
      DRAIN:   state_next = IDLE;
      REJECT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // A start outside IDLE never changes the transfer; it is only flagged.
    if (sd_start && (state_reg != IDLE)) error_next = 2'b10;
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_reg        <= IDLE;
      offset_reg       <= '0;
      block_reg        <= '0;
      error_reg        <= 2'b00;
      rd_pend_reg      <= 1'b0;
      sd_out_reg       <= '0;
      sd_out_valid_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      offset_reg       <= offset_next;
      block_reg        <= block_next;
      error_reg        <= error_next;
      // Read pipeline: stage 1 marks the cycle mem_rdata is valid, stage 2
      // presents that word on sd_out.
      rd_pend_reg      <= rd_strobe;
      sd_out_valid_reg <= rd_pend_reg;
      if (rd_pend_reg) sd_out_reg <= mem_rdata;
    end
  end

  assign sd_ready     = (state_reg == IDLE);
  assign sd_error     = error_reg;
  assign sd_out       = sd_out_reg;
  assign sd_out_valid = sd_out_valid_reg;
  assign mem_addr     = {block_reg, offset_reg};
  assign mem_wen      = wr_strobe;
  assign mem_ren      = rd_strobe;
  assign mem_wdata    = sd_in;

endmodule

// File: tb/tb_sd_card_responder.sv
// tb_sd_card_responder
//   Self-checking bench for sd_card_responder. A transaction-level model
//   tracks what the controller has asked for (which block, how many words
//   moved, which read words are due when) and is checked every cycle.
//   A constant table covers single command responses, hand sequences cover
//   the multi-cycle corner cases, and a randomized phase mixes everything.
module tb_sd_card_responder;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        sd_start = 1'b0;
  logic        sd_mode = 1'b0;
  logic [31:0] sd_block_no = '0;
  logic        sd_load_enable = 1'b0;
  logic [31:0] sd_in = '0;
  logic [31:0] sd_out;
  logic        sd_out_valid;
  logic        sd_ready;
  logic [1:0]  sd_error;
  logic [15:0] mem_addr;
  logic        mem_wen;
  logic        mem_ren;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  sd_card_responder dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .sd_start      (sd_start),
    .sd_mode       (sd_mode),
    .sd_block_no   (sd_block_no),
    .sd_load_enable(sd_load_enable),
    .sd_in         (sd_in),
    .sd_out        (sd_out),
    .sd_out_valid  (sd_out_valid),
    .sd_ready      (sd_ready),
    .sd_error      (sd_error),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_ren       (mem_ren),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  // Backing memory: registered read, one-cycle latency.
  logic [31:0] tb_mem [0:65535];
  bit          mem_init_done = 1'b0;

  function automatic logic [31:0] seed_word(input int a);
    return (32'(a) * 32'h0000_9E37) ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int a = 0; a < 65536; a++) tb_mem[a] <= seed_word(a);
      mem_init_done <= 1'b1;
    end else begin
      if (mem_wen) tb_mem[mem_addr] <= mem_wdata;
      if (mem_ren) mem_rdata <= tb_mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (model cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  rd_t         rdq[$];
  logic [31:0] ref_mem [0:65535];
  int          m_kind;   // 0 none, 1 writing a block, 2 reading a block
  int          m_words;  // words of the current block already moved
  logic [31:0] m_blk;
  int          m_cool;   // cycles the responder still refuses commands
  logic [1:0]  m_err;
  logic [31:0] m_last;

  task automatic model_reset();
    m_kind  = 0;
    m_words = 0;
    m_blk   = '0;
    m_cool  = 0;
    m_err   = 2'b00;
    m_last  = '0;
    rdq.delete();
  endtask

  task automatic model_cycle(input logic st, input logic md, input logic [31:0] bn,
                             input logic le, input logic [31:0] din);
    logic        exp_ready, exp_wen, exp_ren, exp_valid;
    logic [15:0] a;
    int          cool_n;
    rd_t         r;
    exp_ready = (m_kind == 0) && (m_cool == 0);
    exp_wen   = (m_kind == 1) && le;
    exp_ren   = (m_kind == 2) && le;
    a         = 16'(m_blk * 32'd128 + 32'(m_words));
    chk("sd_ready", 32'(sd_ready), 32'(exp_ready));
    chk("mem_wen", 32'(mem_wen), 32'(exp_wen));
    chk("mem_ren", 32'(mem_ren), 32'(exp_ren));
    if (exp_wen || exp_ren) chk("mem_addr", 32'(mem_addr), 32'(a));
    if (exp_wen) chk("mem_wdata", mem_wdata, din);
    exp_valid = (rdq.size() > 0) && (rdq[0].due == cyc);
    chk("sd_out_valid", 32'(sd_out_valid), 32'(exp_valid));
    if (exp_valid) begin
      m_last = rdq[0].data;
      void'(rdq.pop_front());
    end
    chk("sd_out", sd_out, m_last);
    chk("sd_error", 32'(sd_error), 32'(m_err));

    cool_n = (m_cool > 0) ? m_cool - 1 : 0;
    if (exp_wen) begin
      ref_mem[a] = din;
      m_words++;
      if (m_words == 128) m_kind = 0;
    end
    if (exp_ren) begin
      r.due  = cyc + 2;
      r.data = ref_mem[a];
      rdq.push_back(r);
      m_words++;
      if (m_words == 128) begin
        m_kind = 0;
        cool_n = 1;
      end
    end
    if (st) begin
      if (exp_ready) begin
        if (bn < 32'd512) begin
          m_err   = 2'b00;
          m_blk   = bn;
          m_words = 0;
          m_kind  = md ? 1 : 2;
        end else begin
          m_err  = 2'b01;
          cool_n = 1;
        end
      end else begin
        m_err = 2'b10;
      end
    end
    m_cool = cool_n;
    cyc++;
  endtask

  // One clock cycle: drive after the falling edge, sample 1 ns later.
  task automatic step(input logic st, input logic md, input logic [31:0] bn,
                      input logic le, input logic [31:0] din);
    @(negedge clk);
    sd_start       = st;
    sd_mode        = md;
    sd_block_no    = bn;
    sd_load_enable = le;
    sd_in          = din;
    #1;
    model_cycle(st, md, bn, le, din);
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst          = 1'b1;
    sd_start       = 1'b0;
    sd_load_enable = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    model_reset();
  endtask

  // ---------------- single-command table ----------------
  typedef struct {
    logic [31:0] blk;
    logic        mode;
    logic [1:0]  err;
    logic        wen;
    logic        ren;
    logic [15:0] addr;
    logic        ready2;
  } vec_t;

  vec_t vt [6];

  initial begin
    int first_valid, nvalid, k, wcnt;
    bit done;

    for (int a = 0; a < 65536; a++) ref_mem[a] = seed_word(a);
    model_reset();

    vt[0] = '{blk: 32'd0,          mode: 1'b1, err: 2'b00, wen: 1'b1, ren: 1'b0, addr: 16'h0000, ready2: 1'b0};
    vt[1] = '{blk: 32'd511,        mode: 1'b0, err: 2'b00, wen: 1'b0, ren: 1'b1, addr: 16'hFF80, ready2: 1'b0};
    vt[2] = '{blk: 32'd512,        mode: 1'b1, err: 2'b01, wen: 1'b0, ren: 1'b0, addr: 16'h0000, ready2: 1'b1};
    vt[3] = '{blk: 32'hFFFF_FFFF,  mode: 1'b0, err: 2'b01, wen: 1'b0, ren: 1'b0, addr: 16'h0000, ready2: 1'b1};
    vt[4] = '{blk: 32'd300,        mode: 1'b1, err: 2'b00, wen: 1'b1, ren: 1'b0, addr: 16'h9600, ready2: 1'b0};
    vt[5] = '{blk: 32'd513,        mode: 1'b0, err: 2'b01, wen: 1'b0, ren: 1'b0, addr: 16'h0000, ready2: 1'b1};

    // Reset state, sampled while reset is held.
    #3;
    chk("rst_ready", 32'(sd_ready), 32'd1);
    chk("rst_error", 32'(sd_error), 32'd0);
    chk("rst_valid", 32'(sd_out_valid), 32'd0);
    chk("rst_wen", 32'(mem_wen), 32'd0);
    chk("rst_ren", 32'(mem_ren), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_sd_out", sd_out, 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_reset();
      $display("table %0d: block 0x%08h mode %0d", i, vt[i].blk, vt[i].mode);
      step(1'b1, vt[i].mode, vt[i].blk, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_0000 + 32'(i));
      chk("tbl_error", 32'(sd_error), 32'(vt[i].err));
      chk("tbl_ready1", 32'(sd_ready), 32'd0);
      chk("tbl_wen", 32'(mem_wen), 32'(vt[i].wen));
      chk("tbl_ren", 32'(mem_ren), 32'(vt[i].ren));
      if (vt[i].wen || vt[i].ren) chk("tbl_addr", 32'(mem_addr), 32'(vt[i].addr));
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("tbl_ready2", 32'(sd_ready), 32'(vt[i].ready2));
    end
    do_reset();

    // Full block write to block 5.
    $display("seq write: block 5, 128 words");
    step(1'b1, 1'b1, 32'd5, 1'b0, 32'h0);
    for (int i = 0; i < 128; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'hA000 + 32'(i));
      chk("wr_addr", 32'(mem_addr), 32'h0280 + 32'(i));
      chk("wr_data", mem_wdata, 32'hA000 + 32'(i));
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("wr_ready_after", 32'(sd_ready), 32'd1);

    // Full block read of block 5, back-to-back strobes.
    $display("seq read: block 5, 128 back-to-back strobes");
    step(1'b1, 1'b0, 32'd5, 1'b0, 32'h0);
    first_valid = -1;
    nvalid = 0;
    for (int i = 0; i < 130; i++) begin
      step(1'b0, 1'b0, 32'h0, (i < 128), 32'h0);
      if (sd_out_valid) begin
        if (first_valid < 0) first_valid = i;
        chk("rd_data", sd_out, 32'hA000 + 32'(nvalid));
        nvalid++;
      end
      if (i == 128) chk("rd_drain_ready", 32'(sd_ready), 32'd0);
      if (i == 129) chk("rd_ready_back", 32'(sd_ready), 32'd1);
    end
    chk("rd_first_latency", 32'(first_valid), 32'd2);
    chk("rd_count", 32'(nvalid), 32'd128);

    // Stalled write: strobe every other cycle.
    $display("seq stall write: block 7");
    step(1'b1, 1'b1, 32'd7, 1'b0, 32'h0);
    k = 0;
    wcnt = 0;
    done = 1'b0;
    while (!done && k < 400) begin
      step(1'b0, 1'b0, 32'h0, (k % 2 == 0), $urandom);
      if (mem_wen) wcnt++;
      k++;
      if (sd_ready) done = 1'b1;
    end
    chk("stall_writes", 32'(wcnt), 32'd128);
    chk("stall_cycles", 32'(k), 32'd256);

    // Out-of-range start, then a valid start clears the error.
    $display("seq range: block 512 then block 9");
    step(1'b1, 1'b1, 32'd512, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
    chk("range_error", 32'(sd_error), 32'd1);
    chk("range_ready", 32'(sd_ready), 32'd0);
    chk("range_wen", 32'(mem_wen), 32'd0);
    chk("range_ren", 32'(mem_ren), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("range_ready_back", 32'(sd_ready), 32'd1);
    chk("range_error_hold", 32'(sd_error), 32'd1);
    step(1'b1, 1'b0, 32'd9, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("range_error_clear", 32'(sd_error), 32'd0);
    do_reset();

    // Start while busy during a read at offset 40.
    $display("seq busy: start during read of block 5 at offset 40");
    step(1'b1, 1'b0, 32'd5, 1'b0, 32'h0);
    nvalid = 0;
    for (int i = 0; i < 130; i++) begin
      step((i == 40), 1'b1, 32'd3, (i < 128), 32'h0);
      if (sd_out_valid) begin
        chk("busy_rd_data", sd_out, 32'hA000 + 32'(nvalid));
        nvalid++;
      end
      if (i == 41) chk("busy_error", 32'(sd_error), 32'd2);
    end
    chk("busy_rd_count", 32'(nvalid), 32'd128);
    chk("busy_error_hold", 32'(sd_error), 32'd2);

    // Asynchronous reset at write offset 60.
    $display("seq reset: abort write of block 11 at offset 60");
    step(1'b1, 1'b1, 32'd11, 1'b0, 32'h0);
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 32'hB000 + 32'(i));
    @(negedge clk);
    sd_load_enable = 1'b1;
    sd_in          = 32'hB000 + 32'd60;
    #1;
    chk("pre_rst_wen", 32'(mem_wen), 32'd1);
    chk("pre_rst_addr", 32'(mem_addr), 32'(16'h0580 + 16'd60));
    #1;
    n_rst = 1'b1;
    #1;
    chk("arst_wen", 32'(mem_wen), 32'd0);
    chk("arst_ready", 32'(sd_ready), 32'd1);
    chk("arst_addr", 32'(mem_addr), 32'd0);
    chk("arst_valid", 32'(sd_out_valid), 32'd0);
    chk("arst_error", 32'(sd_error), 32'd0);
    chk("arst_sd_out", sd_out, 32'd0);
    model_reset();
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_0000);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_0001);
    n_rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_0002);
    chk("arst_kept_word59", tb_mem[11 * 128 + 59], 32'hB000 + 32'd59);
    chk("arst_untouched_word60", tb_mem[11 * 128 + 60], seed_word(11 * 128 + 60));

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] blk;
      logic        md;
      int          r, n, abort_at;
      n = 0;
      while ((m_kind != 0 || m_cool != 0) && n < 5) begin
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        n++;
      end
      r = int'($urandom % 10);
      if (r < 8)       blk = 32'($urandom_range(0, 511));
      else if (r == 8) blk = 32'd512 + 32'($urandom_range(0, 1000));
      else             blk = $urandom;
      md = 1'($urandom);
      abort_at = ($urandom % 8 == 0) ? int'($urandom_range(1, 150)) : -1;
      $display("txn %0d: block %0d mode %0d abort_at %0d", t, blk, md, abort_at);
      step(1'b1, md, blk, 1'b0, 32'h0);
      n = 0;
      while (m_kind != 0 && n < 1000) begin
        if (n == abort_at) begin
          do_reset();
          break;
        end
        step(($urandom % 50 == 0), 1'($urandom), $urandom, ($urandom % 4 != 0), $urandom);
        n++;
      end
      if (n >= 1000) begin
        checks++;
        errors++;
        $display("FAIL txn_timeout: transaction %0d still busy after %0d cycles, required under 1000", t, n);
      end
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_card_responder.md
SD_CARD_RESPONDER -- requirements
Module: sd_card_responder

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 128, meaning 32-bit words per block (the offset counter is 7 bits wide).
REQ-002 SHALL have parameter NUM_BLOCKS, default 512, meaning the number of addressable blocks in backing memory.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port n_rst, input, 1 bit: asynchronous, active-high reset; n_rst=1 resets the block immediately regardless of clk.
REQ-005 SHALL have port sd_start, input, 1 bit: command strobe from the RAID controller, sampled each clk edge.
REQ-006 SHALL have port sd_mode, input, 1 bit: 1 = write block to card, 0 = read block from card; sampled with sd_start.
REQ-007 SHALL have port sd_block_no, input, 32 bits: target block number; sampled with sd_start.
REQ-008 SHALL have port sd_load_enable, input, 1 bit: per-word transfer strobe.
REQ-009 SHALL have port sd_in, input, 32 bits: write data word from the controller.
REQ-010 SHALL have port sd_out, output, 32 bits: read data word to the controller.
REQ-011 SHALL have port sd_out_valid, output, 1 bit: sd_out holds a valid read word this cycle.
REQ-012 SHALL have port sd_ready, output, 1 bit: responder is idle and accepts sd_start.
REQ-013 SHALL have port sd_error, output, 2 bits: 00 ok, 01 block out of range, 10 start received while busy.
REQ-014 SHALL have ports mem_addr (output, 16 bits), mem_wen (output, 1 bit), mem_ren (output, 1 bit), mem_wdata (output, 32 bits) and mem_rdata (input, 32 bits): backing memory port; mem_rdata is valid one cycle after mem_ren.

Function
REQ-015 SHALL implement an FSM with states IDLE, WRITE_RX, READ_TX, DRAIN and REJECT.
REQ-016 SHALL drive sd_ready=1 only in IDLE.
REQ-017 In IDLE, when sd_start=1 and sd_block_no<NUM_BLOCKS, SHALL latch the block number and mode, clear the offset counter and sd_error to 00, and enter WRITE_RX (mode 1) or READ_TX (mode 0).
REQ-018 In IDLE, when sd_start=1 and sd_block_no>=NUM_BLOCKS, SHALL set sd_error=01, enter REJECT for one cycle, then return to IDLE.
REQ-019 SHALL form mem_addr as {latched_block[8:0], offset[6:0]}.
REQ-020 In WRITE_RX, each cycle with sd_load_enable=1 SHALL assert mem_wen with mem_wdata=sd_in (same cycle, combinational) and increment the offset; a cycle with sd_load_enable=0 SHALL stall without a write.
REQ-021 In WRITE_RX, after the write at offset 127, SHALL return to IDLE on the next edge; the offset SHALL wrap to 0.
REQ-022 In READ_TX, each cycle with sd_load_enable=1 SHALL assert mem_ren at the current offset and increment the offset; back-to-back strobes SHALL be supported.
REQ-023 SHALL register mem_rdata into sd_out with sd_out_valid=1 exactly 2 cycles after the corresponding sd_load_enable, in issue order.
REQ-024 After the read at offset 127 is issued, SHALL enter DRAIN, remain there until the last sd_out_valid has been produced (2 cycles), then go to IDLE.
REQ-025 SHALL drive sd_out_valid=0 when no read is completing; sd_out SHALL hold its last value.
REQ-026 SHALL ignore sd_start outside IDLE, leave the transfer undisturbed, and set sd_error=10; sd_error SHALL hold until the next accepted sd_start.
REQ-027 SHALL ignore sd_load_enable in IDLE, REJECT and DRAIN, with no memory access.
REQ-028 SHALL never assert mem_wen and mem_ren in the same cycle.

Reset
REQ-029 While n_rst=1, SHALL hold state IDLE, offset 0, sd_out=0, sd_out_valid=0, sd_ready=1, sd_error=00, mem_wen=0, mem_ren=0, mem_addr=0, and clear the read pipeline.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer; no further memory access SHALL occur, and the partially written block is left as is.

Verification
REQ-031 Write: sd_start, mode=1, block 5, then 128 strobes with sd_in=offset+0xA000 -> mem_wen at addresses 0x0280..0x02FF with matching data; sd_ready=1 after the last strobe.
REQ-032 Read: preload block 5, sd_start, mode=0, 128 consecutive strobes -> 128 sd_out_valid pulses starting 2 cycles after the first strobe, data in order; sd_ready returns 2 cycles after the last strobe.
REQ-033 Stall: write with sd_load_enable toggling 1/0 -> exactly 128 writes, offsets contiguous, completes after 256 cycles.
REQ-034 Range: sd_start with block 512 -> sd_error=01, sd_ready=0 for one cycle, no memory access; a following valid start clears sd_error to 00.
REQ-035 Busy: sd_start during READ_TX at offset 40 -> sd_error=10, read completes unchanged.
REQ-036 Reset: n_rst=1 at write offset 60 -> outputs at reset values immediately, no mem_wen afterwards.
